// File: rtl/video_pkg.sv
// Shared types and constants for the AXI4-Stream to raw video timing path.
package video_pkg;

    localparam int CNT_W = 12;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster counters producing active-area and sync flags for the
// video output path.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 160,
    parameter int V_BLANK     = 45,
    parameter int HSYNC_WIDTH = 96,
    parameter int VSYNC_LINES = 2
) (
    input  logic             clk,
    input  logic             aresetn,
    output logic [CNT_W-1:0] h_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync,
    output logic             first_slot,
    output logic             last_slot
);

    localparam int EW      = CNT_W + 1;
    localparam int H_TOTAL = IMG_WIDTH + H_BLANK;
    localparam int V_TOTAL = IMG_HEIGHT + V_BLANK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Bounds use one extra bit so a 4096-wide raster cannot overflow.
    localparam logic [EW-1:0] H_ACT    = EW'(IMG_WIDTH);
    localparam logic [EW-1:0] V_ACT    = EW'(IMG_HEIGHT);
    localparam logic [EW-1:0] HS_END   = EW'(IMG_WIDTH + HSYNC_WIDTH);
    localparam logic [EW-1:0] VS_END   = EW'(IMG_HEIGHT + VSYNC_LINES);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [EW-1:0]    h_ext, v_ext;

    always_comb begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_ext      = {1'b0, h_cnt_q};
        v_ext      = {1'b0, v_cnt_q};
        h_cnt      = h_cnt_q;
        active     = (h_ext < H_ACT) && (v_ext < V_ACT);
        hsync      = (h_ext >= H_ACT) && (h_ext < HS_END);
        vsync      = (v_ext >= V_ACT) && (v_ext < VS_END);
        first_slot = (h_cnt_q == '0) && (v_cnt_q == '0);
        last_slot  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

endmodule

// File: rtl/axis_video_out.sv
// AXI4-Stream video to raw vsync/hsync/de timing; pulls beats only in active
// slots and re-locks to start-of-frame after any misalignment.
module axis_video_out
    import video_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 160,
    parameter int V_BLANK     = 45,
    parameter int HSYNC_WIDTH = 96,
    parameter int VSYNC_LINES = 2
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  vid_vsync,
    output logic                  vid_hsync,
    output logic                  vid_de,
    output logic [DATA_WIDTH-1:0] vid_data,
    output logic                  underflow,
    output logic                  sync_err
);

    localparam logic [CNT_W-1:0] H_LAST_PIX = CNT_W'(IMG_WIDTH - 1);

    logic [CNT_W-1:0] h_cnt;
    logic             active, hsync, vsync, first_slot, last_slot;
    logic             beat_err;

    state_t                state_q, state_d;
    logic                  vid_vsync_q, vid_vsync_d;
    logic                  vid_hsync_q, vid_hsync_d;
    logic                  vid_de_q, vid_de_d;
    logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
    logic                  underflow_q, underflow_d;
    logic                  sync_err_q, sync_err_d;

    video_timing_gen #(
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .H_BLANK     (H_BLANK),
        .V_BLANK     (V_BLANK),
        .HSYNC_WIDTH (HSYNC_WIDTH),
        .VSYNC_LINES (VSYNC_LINES)
    ) u_timing (
        .clk        (s_axis_aclk),
        .aresetn    (s_axis_aresetn),
        .h_cnt      (h_cnt),
        .active     (active),
        .hsync      (hsync),
        .vsync      (vsync),
        .first_slot (first_slot),
        .last_slot  (last_slot)
    );

    // tlast must appear exactly on the last pixel of a line, tuser only at (0,0).
    always_comb begin
        beat_err = (s_axis_tuser && !first_slot) ||
                   (s_axis_tlast != (h_cnt == H_LAST_PIX));
    end

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        vid_vsync_d   = vsync;
        vid_hsync_d   = hsync;
        vid_de_d      = 1'b0;
        vid_data_d    = '0;
        underflow_d   = 1'b0;
        sync_err_d    = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                // Non-SOF beats are flushed; the SOF beat waits for the raster wrap.
                s_axis_tready = s_axis_tvalid && !s_axis_tuser;
                if (last_slot && s_axis_tvalid && s_axis_tuser) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                s_axis_tready = active;
                if (active) begin
                    vid_de_d = 1'b1;
                    if (!s_axis_tvalid) begin
                        underflow_d = 1'b1;
                    end else if (beat_err) begin
                        sync_err_d = 1'b1;
                        state_d    = WAIT_SOF;
                    end else begin
                        vid_data_d = s_axis_tdata;
                    end
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state_q     <= WAIT_SOF;
            vid_vsync_q <= 1'b0;
            vid_hsync_q <= 1'b0;
            vid_de_q    <= 1'b0;
            vid_data_q  <= '0;
            underflow_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vid_vsync_q <= vid_vsync_d;
            vid_hsync_q <= vid_hsync_d;
            vid_de_q    <= vid_de_d;
            vid_data_q  <= vid_data_d;
            underflow_q <= underflow_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign vid_vsync = vid_vsync_q;
    assign vid_hsync = vid_hsync_q;
    assign vid_de    = vid_de_q;
    assign vid_data  = vid_data_q;
    assign underflow = underflow_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_axis_video_out.sv
// Directed bench for axis_video_out on a small 8x4 raster (12x6 total, 72-clock frame).
module tb_axis_video_out;

    localparam int DW = 64;

    logic          clk;
    logic          aresetn;
    logic [DW-1:0] tdata;
    logic          tuser, tlast, tvalid, tready;
    logic          vsync, hsync, de, underflow, sync_err;
    logic [DW-1:0] vdata;

    int tests_run;
    int tests_failed;
    int slot;

    typedef struct {
        logic          valid;
        logic          user;
        logic          last;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic          exp_de;
        logic          exp_uf;
        logic          exp_se;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t garbage_vecs[3];
    vec_t err_vecs[12];

    axis_video_out #(
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (8),
        .IMG_HEIGHT  (4),
        .H_BLANK     (4),
        .V_BLANK     (2),
        .HSYNC_WIDTH (2),
        .VSYNC_LINES (1)
    ) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (aresetn),
        .s_axis_tdata   (tdata),
        .s_axis_tuser   (tuser),
        .s_axis_tlast   (tlast),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .vid_vsync      (vsync),
        .vid_hsync      (hsync),
        .vid_de         (de),
        .vid_data       (vdata),
        .underflow      (underflow),
        .sync_err       (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (slot %0d)", name, act, exp, slot);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic u, input logic l, input logic [DW-1:0] d);
        tvalid = v;
        tuser  = u;
        tlast  = l;
        tdata  = d;
        #1;
    endtask

    // One clock: drive inputs, check tready, clock, then check registered outputs
    // against the raster position that was live before the edge.
    task automatic run_cycle(input logic v, input logic u, input logic l, input logic [DW-1:0] d,
                             input logic e_ready, input logic e_de, input logic e_uf,
                             input logic e_se, input logic [DW-1:0] e_data, input string tag);
        int ph, pv;
        ph = slot % 12;
        pv = (slot / 12) % 6;
        applyStimulus(v, u, l, d);
        checkOutput({tag, " tready"}, DW'(tready), DW'(e_ready));
        @(posedge clk);
        slot++;
        #1;
        checkOutput({tag, " de"}, DW'(de), DW'(e_de));
        checkOutput({tag, " data"}, vdata, e_data);
        checkOutput({tag, " underflow"}, DW'(underflow), DW'(e_uf));
        checkOutput({tag, " sync_err"}, DW'(sync_err), DW'(e_se));
        checkOutput({tag, " hsync"}, DW'(hsync), DW'(ph == 8 || ph == 9));
        checkOutput({tag, " vsync"}, DW'(vsync), DW'(pv == 4));
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        run_cycle(t.valid, t.user, t.last, t.data, t.exp_ready, t.exp_de, t.exp_uf, t.exp_se,
                  t.exp_data, tag);
    endtask

    // A well-formed source aligned to the raster; blanking slots offer a junk
    // beat that must not be taken. uf_mode drops the beats at h=3,4 of line 0.
    task automatic pixel_slot(input logic [DW-1:0] base, input bit uf_mode, input string tag);
        int h, v, idx;
        h   = slot % 12;
        v   = (slot / 12) % 6;
        idx = v * 8 + h;
        if (h < 8 && v < 4) begin
            if (uf_mode && v == 0 && (h == 3 || h == 4))
                run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, '0, tag);
            else
                run_cycle(1'b1, idx == 0, h == 7, base + DW'(idx),
                          1'b1, 1'b1, 1'b0, 1'b0, base + DW'(idx), tag);
        end else begin
            run_cycle(1'b1, 1'b0, 1'b0, 64'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, '0, tag);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " tready"}, DW'(tready), '0);
        checkOutput({tag, " de"}, DW'(de), '0);
        checkOutput({tag, " data"}, vdata, '0);
        checkOutput({tag, " hsync"}, DW'(hsync), '0);
        checkOutput({tag, " vsync"}, DW'(vsync), '0);
        checkOutput({tag, " underflow"}, DW'(underflow), '0);
        checkOutput({tag, " sync_err"}, DW'(sync_err), '0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        slot         = 0;

        // Non-SOF beats in WAIT_SOF: taken immediately, never displayed.
        garbage_vecs[0] = '{1'b1, 1'b0, 1'b0, 64'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        garbage_vecs[1] = '{1'b1, 1'b0, 1'b1, 64'hBBBB, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        garbage_vecs[2] = '{1'b1, 1'b0, 1'b0, 64'hCCCC, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};

        // Line 1 of a frame with a premature tlast at h=5.
        err_vecs[0]  = '{1'b1, 1'b0, 1'b0, 64'd8,  1'b1, 1'b1, 1'b0, 1'b0, 64'd8};
        err_vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'd9,  1'b1, 1'b1, 1'b0, 1'b0, 64'd9};
        err_vecs[2]  = '{1'b1, 1'b0, 1'b0, 64'd10, 1'b1, 1'b1, 1'b0, 1'b0, 64'd10};
        err_vecs[3]  = '{1'b1, 1'b0, 1'b0, 64'd11, 1'b1, 1'b1, 1'b0, 1'b0, 64'd11};
        err_vecs[4]  = '{1'b1, 1'b0, 1'b0, 64'd12, 1'b1, 1'b1, 1'b0, 1'b0, 64'd12};
        err_vecs[5]  = '{1'b1, 1'b0, 1'b1, 64'd13, 1'b1, 1'b1, 1'b0, 1'b1, 64'd0};
        err_vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        err_vecs[7]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        err_vecs[8]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        err_vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        err_vecs[10] = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
        err_vecs[11] = '{1'b0, 1'b0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0};

        aresetn = 1'b0;
        tvalid  = 1'b0;
        tuser   = 1'b0;
        tlast   = 1'b0;
        tdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        aresetn = 1'b1;
        slot    = 0;

        for (int i = 0; i < 3; i++) run_vec(garbage_vecs[i], "garbage");

        // SOF beat is held until the raster reaches its last slot.
        while (slot < 72)
            run_cycle(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "sof_hold");

        while (slot < 144) pixel_slot(64'd0, 1'b0, "frame1");
        while (slot < 216) pixel_slot(64'd0, 1'b1, "frame2_uf");

        while (slot < 228) pixel_slot(64'd0, 1'b0, "frame3");
        for (int i = 0; i < 12; i++) run_vec(err_vecs[i], "sync_err_line");
        while (slot < 240 + 12)
            run_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, "blanked");
        while (slot < 288)
            run_cycle(1'b1, 1'b1, 1'b0, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0, '0, "relock_hold");

        while (slot < 315) pixel_slot(64'h1000, 1'b0, "frame4_relock");

        // One-cycle reset in the middle of line 2.
        aresetn = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        aresetn = 1'b1;
        slot    = 0;
        while (slot < 24)
            run_cycle(1'b1, 1'b1, 1'b0, 64'h2000, 1'b0, 1'b0, 1'b0, 1'b0, '0, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
